// File: rtl/note_player_if.sv
// note_player_if: note interface between the song reader (master) and the
// note player bank (slave). Carries incoming note strobes and the per-voice
// status reported back to the synthesis stage.
interface note_player_if #(
    parameter int VOICES = 3,
    parameter int DUR_W  = 6
);
    logic                  play;
    logic                  beat;
    logic                  new_note;
    logic [5:0]            note;
    logic [DUR_W-1:0]      duration;
    logic [2:0]            metadata;
    logic [6*VOICES-1:0]   voice_note;
    logic [3*VOICES-1:0]   voice_meta;
    logic [VOICES-1:0]     voice_en;
    logic                  note_done;
    logic [VOICES-1:0]     done_mask;
    logic                  dropped;
    logic                  busy;

    modport master (
        output play, beat, new_note, note, duration, metadata,
        input  voice_note, voice_meta, voice_en, note_done, done_mask, dropped, busy
    );

    modport slave (
        input  play, beat, new_note, note, duration, metadata,
        output voice_note, voice_meta, voice_en, note_done, done_mask, dropped, busy
    );
endinterface

// File: rtl/note_player_bank.sv
// note_player_bank: assigns incoming notes to the lowest free of VOICES voice
// slots, counts each voice down in beats and reports per-voice note, metadata
// and enable. Pulses note_done/done_mask on expiry and dropped when no voice
// is free.
// Optional feature macro: NOTE_PLAYER_STEAL_EN -- when defined, a note with no
// free voice steals the playing voice with the smallest remaining count
// (lowest index on ties) instead of being dropped.
module note_player_bank #(
    parameter int VOICES = 3,
    parameter int DUR_W  = 6
) (
    input  logic           clk,
    input  logic           reset,
    note_player_if.slave   bus
);

    typedef enum logic {
        V_IDLE = 1'b0,
        V_PLAY = 1'b1
    } voice_state_t;

    localparam logic [DUR_W-1:0] REM_ONE = {{(DUR_W-1){1'b0}}, 1'b1};

    // Voice state
    voice_state_t        r_state     [VOICES];
    voice_state_t        w_state_nxt [VOICES];
    logic [DUR_W-1:0]    r_rem       [VOICES];
    logic [DUR_W-1:0]    w_rem_nxt   [VOICES];
    logic [5:0]          r_note      [VOICES];
    logic [5:0]          w_note_nxt  [VOICES];
    logic [2:0]          r_meta      [VOICES];
    logic [2:0]          w_meta_nxt  [VOICES];

    // Allocation / countdown control
    logic                w_tick;
    logic                w_req;
    logic                w_drop;
    logic [VOICES-1:0]   w_free;
    logic [VOICES-1:0]   w_load;
    logic [VOICES-1:0]   w_expire;
    logic [VOICES-1:0]   w_active_nxt;

    // Registered outputs
    logic [VOICES-1:0]   r_voice_en;
    logic                r_note_done;
    logic [VOICES-1:0]   r_done_mask;
    logic                r_dropped;
    logic                r_busy;
    logic [6*VOICES-1:0] w_voice_note;
    logic [3*VOICES-1:0] w_voice_meta;

    // One-hot of the lowest set bit of mask (zero when mask is empty).
    function automatic logic [VOICES-1:0] first_one(input logic [VOICES-1:0] mask);
        logic [VOICES-1:0] sel;
        sel = {VOICES{1'b0}};
        for (int i = VOICES - 1; i >= 0; i--) begin
            sel = mask[i] ? ({{(VOICES-1){1'b0}}, 1'b1} << i) : sel;
        end
        return sel;
    endfunction

`ifdef NOTE_PLAYER_STEAL_EN
    logic [VOICES-1:0]   w_steal;
    logic [DUR_W-1:0]    w_best_rem;
    logic                w_found;
    logic                w_take;

    // Pick the playing voice closest to expiry; strict compare keeps the lowest index on ties.
    always_comb begin
        w_steal    = {VOICES{1'b0}};
        w_best_rem = {DUR_W{1'b1}};
        w_found    = 1'b0;
        w_take     = 1'b0;
        for (int i = 0; i < VOICES; i++) begin
            w_take     = (r_state[i] == V_PLAY) && (!w_found || (r_rem[i] < w_best_rem));
            w_steal    = w_take ? ({{(VOICES-1){1'b0}}, 1'b1} << i) : w_steal;
            w_best_rem = w_take ? r_rem[i] : w_best_rem;
            w_found    = w_found | w_take;
        end
    end
`endif

    // Choose which voice (if any) loads the incoming note; the free mask is pre-edge state.
    always_comb begin
        w_tick = bus.beat & bus.play;
        w_req  = bus.new_note & (bus.duration != {DUR_W{1'b0}});
        w_load = {VOICES{1'b0}};
        w_drop = 1'b0;
        for (int i = 0; i < VOICES; i++) begin
            w_free[i] = (r_state[i] == V_IDLE);
        end
        if (w_req) begin
            if (|w_free) begin
                w_load = first_one(w_free);
            end else begin
`ifdef NOTE_PLAYER_STEAL_EN
                w_load = w_steal;
`else
                w_drop = 1'b1;
`endif
            end
        end else begin
            w_load = {VOICES{1'b0}};
        end
    end

    // Per-voice next state: load has priority over countdown; remaining==1 retires the voice.
    always_comb begin
        for (int i = 0; i < VOICES; i++) begin
            w_state_nxt[i] = r_state[i];
            w_rem_nxt[i]   = r_rem[i];
            w_note_nxt[i]  = r_note[i];
            w_meta_nxt[i]  = r_meta[i];
            w_expire[i]    = 1'b0;
            if (w_load[i]) begin
                w_state_nxt[i] = V_PLAY;
                w_rem_nxt[i]   = bus.duration;
                w_note_nxt[i]  = bus.note;
                w_meta_nxt[i]  = bus.metadata;
            end else begin
                case (r_state[i])
                    V_IDLE: begin
                        w_state_nxt[i] = V_IDLE;
                    end
                    V_PLAY: begin
                        if (w_tick) begin
                            if (r_rem[i] == REM_ONE) begin
                                w_state_nxt[i] = V_IDLE;
                                w_expire[i]    = 1'b1;
                            end else begin
                                w_rem_nxt[i]   = r_rem[i] - REM_ONE;
                            end
                        end else begin
                            w_state_nxt[i] = V_PLAY;
                        end
                    end
                    default: begin
                        w_state_nxt[i] = V_IDLE;
                    end
                endcase
            end
            w_active_nxt[i] = (w_state_nxt[i] == V_PLAY);
        end
    end

    // Voice state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < VOICES; i++) begin
                r_state[i] <= V_IDLE;
                r_rem[i]   <= {DUR_W{1'b0}};
                r_note[i]  <= 6'd0;
                r_meta[i]  <= 3'd0;
            end
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_rem[i]   <= w_rem_nxt[i];
                r_note[i]  <= w_note_nxt[i];
                r_meta[i]  <= w_meta_nxt[i];
            end
        end
    end

    // Status outputs, registered so they line up with the voice state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_voice_en  <= {VOICES{1'b0}};
            r_note_done <= 1'b0;
            r_done_mask <= {VOICES{1'b0}};
            r_dropped   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_voice_en  <= w_active_nxt & {VOICES{bus.play}};
            r_note_done <= |w_expire;
            r_done_mask <= w_expire;
            r_dropped   <= w_drop;
            r_busy      <= |w_active_nxt;
        end
    end

    // Flatten per-voice note/meta registers onto the output buses.
    always_comb begin
        w_voice_note = {(6*VOICES){1'b0}};
        w_voice_meta = {(3*VOICES){1'b0}};
        for (int i = 0; i < VOICES; i++) begin
            w_voice_note[6*i +: 6] = r_note[i];
            w_voice_meta[3*i +: 3] = r_meta[i];
        end
    end

    assign bus.voice_note = w_voice_note;
    assign bus.voice_meta = w_voice_meta;
    assign bus.voice_en   = r_voice_en;
    assign bus.note_done  = r_note_done;
    assign bus.done_mask  = r_done_mask;
    assign bus.dropped    = r_dropped;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_note_player_bank.sv
// tb_note_player_bank: directed stimulus for note_player_bank with a
// behavioural voice model compared on every falling edge, plus literal
// expectations at the key points of each scenario.
module tb_note_player_bank;
    localparam int VOICES = 3;
    localparam int DUR_W  = 6;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    note_player_if #(.VOICES(VOICES), .DUR_W(DUR_W)) bus ();

    note_player_bank #(.VOICES(VOICES), .DUR_W(DUR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- behavioural model ----------------
    bit         m_active [3];
    int         m_rem    [3];
    logic [5:0] m_note   [3];
    logic [2:0] m_meta   [3];
    logic [2:0] e_en, e_mask;
    logic       e_done, e_drop, e_busy;
    int         tgt;
    bit         drop;
    logic [2:0] expd;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_active[i] = 1'b0; m_rem[i] = 0; m_note[i] = 6'd0; m_meta[i] = 3'd0;
            end
            e_en = 3'd0; e_mask = 3'd0; e_done = 1'b0; e_drop = 1'b0; e_busy = 1'b0;
        end else begin
            tgt = -1; drop = 1'b0; expd = 3'd0;
            if (bus.new_note && bus.duration != 0) begin
                for (int i = 0; i < 3; i++) if (tgt < 0 && !m_active[i]) tgt = i;
                if (tgt < 0) begin
`ifdef NOTE_PLAYER_STEAL_EN
                    tgt = 0;
                    for (int i = 1; i < 3; i++) if (m_rem[i] < m_rem[tgt]) tgt = i;
`else
                    drop = 1'b1;
`endif
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (i == tgt) begin
                    m_active[i] = 1'b1; m_rem[i] = int'(bus.duration);
                    m_note[i] = bus.note; m_meta[i] = bus.metadata;
                end else if (m_active[i] && bus.beat && bus.play) begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) begin
                        m_active[i] = 1'b0; expd[i] = 1'b1;
                    end
                end
            end
            for (int i = 0; i < 3; i++) e_en[i] = m_active[i] && bus.play;
            e_mask = expd;
            e_done = (expd != 3'd0);
            e_drop = drop;
            e_busy = m_active[0] || m_active[1] || m_active[2];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model each cycle, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("voice_note", 32'(bus.voice_note), 32'({m_note[2], m_note[1], m_note[0]}));
            chk("voice_meta", 32'(bus.voice_meta), 32'({m_meta[2], m_meta[1], m_meta[0]}));
            chk("voice_en",   32'(bus.voice_en),   32'(e_en));
            chk("note_done",  32'(bus.note_done),  32'(e_done));
            chk("done_mask",  32'(bus.done_mask),  32'(e_mask));
            chk("dropped",    32'(bus.dropped),    32'(e_drop));
            chk("busy",       32'(bus.busy),       32'(e_busy));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic b, input logic nn, input logic [5:0] n,
                         input logic [5:0] d, input logic [2:0] m);
        bus.beat = b; bus.new_note = nn; bus.note = n; bus.duration = d; bus.metadata = m;
        @(posedge clk);
        #1;
        bus.beat = 1'b0; bus.new_note = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 6'd0, 6'd0, 3'd0);
    endtask

    task automatic beat1();
        drive(1'b1, 1'b0, 6'd0, 6'd0, 3'd0);
    endtask

    task automatic note_in(input logic [5:0] n, input logic [5:0] d, input logic [2:0] m);
        drive(1'b0, 1'b1, n, d, m);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},   32'(bus.voice_en),   32'd0);
        chk({tag, "_note"}, 32'(bus.voice_note), 32'd0);
        chk({tag, "_meta"}, 32'(bus.voice_meta), 32'd0);
        chk({tag, "_done"}, 32'(bus.note_done),  32'd0);
        chk({tag, "_mask"}, 32'(bus.done_mask),  32'd0);
        chk({tag, "_drop"}, 32'(bus.dropped),    32'd0);
        chk({tag, "_busy"}, 32'(bus.busy),       32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.play = 1'b0; bus.beat = 1'b0; bus.new_note = 1'b0;
        bus.note = 6'd0; bus.duration = 6'd0; bus.metadata = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        bus.play = 1'b1;
        idle();

        // Single note: note 12, duration 3, then 3 beats
        note_in(6'd12, 6'd3, 3'd5);
        chk("single_en",   32'(bus.voice_en), 32'h1);
        chk("single_note", 32'(bus.voice_note[5:0]), 32'd12);
        chk("single_meta", 32'(bus.voice_meta[2:0]), 32'd5);
        beat1(); idle(); beat1(); idle();
        chk("single_notyet", 32'(bus.note_done), 32'd0);
        beat1();
        chk("single_done", 32'(bus.note_done), 32'd1);
        chk("single_mask", 32'(bus.done_mask), 32'h1);
        chk("single_en_off", 32'(bus.voice_en), 32'h0);
        idle();
        chk("single_done_pulse", 32'(bus.note_done), 32'd0);
        chk("single_note_hold", 32'(bus.voice_note[5:0]), 32'd12);

        // Chord: durations 2, 2, 5 then 2 beats
        note_in(6'd20, 6'd2, 3'd1);
        note_in(6'd21, 6'd2, 3'd2);
        note_in(6'd22, 6'd5, 3'd3);
        chk("chord_en", 32'(bus.voice_en), 32'h7);
        chk("chord_notes", 32'(bus.voice_note), 32'((22 << 12) | (21 << 6) | 20));
        beat1(); idle(); beat1();
        chk("chord_done", 32'(bus.note_done), 32'd1);
        chk("chord_mask", 32'(bus.done_mask), 32'h3);
        chk("chord_en2",  32'(bus.voice_en), 32'h4);
        note_in(6'd30, 6'd4, 3'd0);
        chk("chord_4th_en",   32'(bus.voice_en), 32'h5);
        chk("chord_4th_note", 32'(bus.voice_note[5:0]), 32'd30);
        repeat (4) begin beat1(); idle(); end
        chk("chord_drained", 32'(bus.busy), 32'd0);

        // Overflow: remaining 4, 2, 2 then a 4th note
        note_in(6'd1, 6'd4, 3'd0);
        note_in(6'd2, 6'd2, 3'd0);
        note_in(6'd3, 6'd2, 3'd0);
        note_in(6'd40, 6'd6, 3'd7);
`ifdef NOTE_PLAYER_STEAL_EN
        chk("ovf_dropped", 32'(bus.dropped), 32'd0);
        chk("ovf_v1_note", 32'(bus.voice_note[11:6]), 32'd40);
        chk("ovf_v1_meta", 32'(bus.voice_meta[5:3]), 32'd7);
`else
        chk("ovf_dropped", 32'(bus.dropped), 32'd1);
        chk("ovf_v1_note", 32'(bus.voice_note[11:6]), 32'd2);
        chk("ovf_v1_meta", 32'(bus.voice_meta[5:3]), 32'd0);
`endif
        chk("ovf_en",   32'(bus.voice_en), 32'h7);
        chk("ovf_done", 32'(bus.note_done), 32'd0);
        idle();
        chk("ovf_drop_pulse", 32'(bus.dropped), 32'd0);
        repeat (6) begin beat1(); idle(); end
        chk("ovf_drained", 32'(bus.busy), 32'd0);

        // Pause: duration 2, one beat, 10 beats with play low, then resume
        note_in(6'd9, 6'd2, 3'd1);
        beat1();
        bus.play = 1'b0;
        repeat (10) beat1();
        chk("pause_en",   32'(bus.voice_en), 32'h0);
        chk("pause_busy", 32'(bus.busy), 32'd1);
        chk("pause_done", 32'(bus.note_done), 32'd0);
        note_in(6'd11, 6'd3, 3'd2);
        chk("pause_accept_busy", 32'(bus.voice_en), 32'h0);
        bus.play = 1'b1;
        beat1();
        chk("resume_done", 32'(bus.note_done), 32'd1);
        chk("resume_mask", 32'(bus.done_mask), 32'h1);
        chk("resume_en",   32'(bus.voice_en), 32'h2);
        repeat (2) begin beat1(); idle(); end

        // Duration 0 is ignored
        note_in(6'd5, 6'd0, 3'd6);
        chk("dur0_busy", 32'(bus.busy), 32'd0);
        chk("dur0_drop", 32'(bus.dropped), 32'd0);
        chk("dur0_en",   32'(bus.voice_en), 32'h0);

        // Note arriving on the beat that expires voice 0 while voices 1, 2 busy
        note_in(6'd7, 6'd1, 3'd0);
        note_in(6'd8, 6'd5, 3'd0);
        note_in(6'd9, 6'd5, 3'd0);
        drive(1'b1, 1'b1, 6'd50, 6'd3, 3'd4);
`ifdef NOTE_PLAYER_STEAL_EN
        chk("edge_done", 32'(bus.note_done), 32'd0);
        chk("edge_drop", 32'(bus.dropped), 32'd0);
        chk("edge_note", 32'(bus.voice_note[5:0]), 32'd50);
`else
        chk("edge_done", 32'(bus.note_done), 32'd1);
        chk("edge_mask", 32'(bus.done_mask), 32'h1);
        chk("edge_drop", 32'(bus.dropped), 32'd1);
        chk("edge_note", 32'(bus.voice_note[5:0]), 32'd7);
`endif
        idle();

        // Asynchronous reset mid-cycle with voices 1 and 2 playing
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) begin beat1(); idle(); end
        chk("post_reset_done", 32'(bus.note_done), 32'd0);
        chk("post_reset_busy", 32'(bus.busy), 32'd0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
